pipe_slice: RTL

PIPE_SLICE -- requirements
Module: pipe_slice

---
 rtl/pipe_slice_pkg.sv | 30 +++
 rtl/pipe_slice_skid.sv | 77 +++++++
 rtl/pipe_slice.sv | 89 ++++++++
 3 files changed

// File: rtl/pipe_slice_pkg.sv
// -----------------------------------------------------------------------------
// pipe_slice_pkg
// Shared constants and helpers for the pipe_slice skid-buffer pipeline.
//   DEPTH_MAX   : largest supported number of skid stages
//   WIDTH_MAX   : largest supported payload width
//   clog2()     : ceiling log2, usable in constant expressions
//   level_width : width of the fill-level counter for a given DEPTH (min 1)
// -----------------------------------------------------------------------------
package pipe_slice_pkg;

    localparam int DEPTH_MAX = 8;
    localparam int WIDTH_MAX = 64;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Level counts 0..2*DEPTH, so it needs clog2(2*DEPTH+1) bits, never zero.
    function automatic int level_width(input int depth);
        int w;
        w = clog2(2 * depth + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pipe_slice_skid.sv
// -----------------------------------------------------------------------------
// skid_stage
// One two-entry pipeline stage: a main register feeding the output and a skid
// register that catches the word arriving in the cycle the registered ready
// could not yet fall. Both ready and output are driven straight from flops.
//   clk, rst_n : clock, synchronous active-low reset
//   i_data     : upstream payload         i_valid : upstream valid
//   o_ready    : stage can accept         (registered, = not skid-full)
//   o_data     : downstream payload       o_valid : downstream valid
//   i_ready    : downstream accepts o_data this cycle
// -----------------------------------------------------------------------------
module skid_stage
    import pipe_slice_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    logic [WIDTH-1:0] r_main_data;
    logic             r_main_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_skid_valid;
    logic             r_ready;

    logic w_in_fire;
    logic w_out_fire;

    assign w_in_fire  = i_valid & r_ready;
    assign w_out_fire = r_main_valid & i_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: payload registers are cleared too; only the valid flags
            // matter functionally, but this keeps y at 0 after reset.
            r_main_data  <= '0;
            r_main_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
            r_ready      <= 1'b1;
        end else if (!r_main_valid || w_out_fire) begin
            // Main is free this cycle. A held skid word always goes first;
            // while skid is full r_ready is low, so no new word can arrive.
            if (r_skid_valid) begin
                r_main_data  <= r_skid_data;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
                r_ready      <= 1'b1;
            end else if (w_in_fire) begin
                r_main_data  <= i_data;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_in_fire) begin
            // Main stalled: the word accepted on the still-high ready is
            // parked in skid and ready drops for the next cycle.
            r_skid_data  <= i_data;
            r_skid_valid <= 1'b1;
            r_ready      <= 1'b0;
        end
    end

    assign o_ready = r_ready;
    assign o_data  = r_main_data;
    assign o_valid = r_main_valid;

endmodule

// File: rtl/pipe_slice.sv
// -----------------------------------------------------------------------------
// pipe_slice
// Valid/ready pipeline slice of DEPTH chained skid stages (2 words each).
// DEPTH=0 collapses to wires. Latency DEPTH cycles, one word per cycle.
//   clk, rst_n      : clock, synchronous active-low reset
//   a, a_valid      : upstream payload / valid
//   a_ready         : block can accept a this cycle
//   y, y_valid      : downstream payload / valid
//   y_ready         : downstream accepts y this cycle
//   level           : number of words currently held (0..2*DEPTH)
// -----------------------------------------------------------------------------
module pipe_slice
    import pipe_slice_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int LW    = level_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic             a_valid,
    output logic             a_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [LW-1:0]    level
);

    if (WIDTH < 1 || WIDTH > WIDTH_MAX || DEPTH < 0 || DEPTH > DEPTH_MAX) begin : g_bad_param
        $error("pipe_slice: WIDTH or DEPTH out of range");
    end

    if (DEPTH == 0) begin : g_pass
        assign y       = a;
        assign y_valid = a_valid;
        assign a_ready = y_ready;
        assign level   = '0;
    end else begin : g_pipe
        // Index g is the link feeding stage g; index DEPTH is the output.
        logic [WIDTH-1:0] w_data [0:DEPTH];
        logic [DEPTH:0]   w_valid;
        logic [DEPTH:0]   w_ready;
        logic             w_accept;
        logic             w_drain;
        logic [LW-1:0]    r_level;

        assign w_data[0]      = a;
        assign w_valid[0]     = a_valid;
        assign w_ready[DEPTH] = y_ready;

        for (genvar g = 0; g < DEPTH; g++) begin : g_stage
            skid_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_data  (w_data[g]),
                .i_valid (w_valid[g]),
                .o_ready (w_ready[g]),
                .o_data  (w_data[g+1]),
                .o_valid (w_valid[g+1]),
                .i_ready (w_ready[g+1])
            );
        end

        assign y       = w_data[DEPTH];
        assign y_valid = w_valid[DEPTH];
        // Ready reads high while reset is held; the stages ignore the
        // handshake in that cycle because their reset branch wins.
        assign a_ready = w_ready[0] | ~rst_n;

        assign w_accept = a_valid & w_ready[0];
        assign w_drain  = w_valid[DEPTH] & y_ready;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_level <= '0;
            end else if (w_accept && !w_drain) begin
                r_level <= r_level + LW'(1);
            end else if (w_drain && !w_accept) begin
                r_level <= r_level - LW'(1);
            end
        end

        assign level = r_level;
    end

endmodule
